// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter sequencing one doubleword access at a time into a single-ported data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0 wins) otherwise.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_write,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_write,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic                  owner, wr, err, win, any_valid, req_hs, rsp_hs, misaligned;
    logic [ADDR_WIDTH-1:0] addr, sel_addr;
    logic [DATA_WIDTH-1:0] wdata, rdata, sel_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign win = (p0_req_valid & p1_req_valid) ? ~last_grant : p1_req_valid;
`else
    assign win = ~p0_req_valid;
`endif

    // ready is gated by rst_n so both ports see ready=0 while reset is held
    assign any_valid    = p0_req_valid | p1_req_valid;
    assign p0_req_ready = rst_n & (state == IDLE) & any_valid & ~win;
    assign p1_req_ready = rst_n & (state == IDLE) & any_valid & win;
    assign req_hs       = p0_req_ready | p1_req_ready;
    assign sel_addr     = win ? p1_req_addr : p0_req_addr;
    assign sel_wdata    = win ? p1_req_wdata : p0_req_wdata;
    assign misaligned   = |sel_addr[ALIGN_BITS-1:0];
    assign rsp_hs       = owner ? p1_rsp_ready : p0_rsp_ready;
    assign mem_addr     = addr;
    assign mem_wdata    = wdata;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata : '0;
    assign p0_rsp_err   = p0_rsp_valid & err;
    assign p1_rsp_err   = p1_rsp_valid & err;

    always_comb begin
        state_nxt    = state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        case (state)
            IDLE: if (req_hs) state_nxt = misaligned ? RESP : ACCESS;
            ACCESS: begin
                state_nxt = RESP;
                mem_read  = ~wr;
                mem_write = wr;
            end
            RESP: begin
                p0_rsp_valid = ~owner;
                p1_rsp_valid = owner;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            wr    <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (req_hs) begin
                owner <= win;
                wr    <= win ? p1_req_write : p0_req_write;
                addr  <= sel_addr;
                wdata <= sel_wdata;
                rdata <= '0;
                err   <= misaligned;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                last_grant <= win;
`endif
            end
            if (state == ACCESS && !wr) rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed stimulus against a transaction-level reference model of dmem_arbiter.
module tb_dmem_arbiter;
    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v[2], w[2], rr[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    logic          p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata, mem_wdata, mem_rdata;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem [64];
    logic [DW-1:0] ref_mem [8];
    int            n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(v[0]), .p0_req_ready(p0_req_ready), .p0_req_write(w[0]), .p0_req_addr(a[0]),
        .p0_req_wdata(d[0]), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(rr[0]), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(v[1]), .p1_req_ready(p1_req_ready), .p1_req_write(w[1]), .p1_req_addr(a[1]),
        .p1_req_wdata(d[1]), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(rr[1]), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // byte-addressed little-endian memory, combinational read
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i+:8] = mem[mem_addr + AW'(i)];
    end
    always @(posedge clk) if (mem_write) for (int i = 0; i < 8; i++) mem[mem_addr + AW'(i)] <= mem_wdata[8*i+:8];

    function automatic logic [DW-1:0] word(input logic [AW-1:0] ad);
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[8*i+:8] = mem[ad + AW'(i)];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: one transaction in flight, timing derived from its accept cycle
    int            cyc = 0, acc_cyc = 0, rsp_cyc = 0;
    bit            busy = 0, owner = 0, m_wr = 0, last = 1, exp_err = 0, win, acc;
    bit            hs[2];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0, exp_rd = '0;
    logic [1:0]    er, ev;
    int            grants[$];

    always @(negedge clk) begin
        cyc++;
        for (int p = 0; p < 2; p++) hs[p] = v[p] && (p == 0 ? p0_req_ready : p1_req_ready);
        for (int p = 0; p < 2; p++) if (hs[p]) grants.push_back(p);
        if (!rst_n) begin
            check("rst_ctl", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
                              p0_rsp_err, p1_rsp_err, mem_read, mem_write}, 0);
            check("rst_rdata0", p0_rsp_rdata, 0);
            check("rst_rdata1", p1_rsp_rdata, 0);
            check("rst_mem_addr", 64'(mem_addr), 0);
            check("rst_mem_wdata", mem_wdata, 0);
            busy = 0; last = 1; m_addr = '0; m_wd = '0;
        end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            win = (v[0] && v[1]) ? !last : v[1];
`else
            win = !v[0];
`endif
            er = 2'b00;
            if (!busy && (v[0] || v[1])) er[win] = 1'b1;
            ev = 2'b00;
            if (busy && cyc >= rsp_cyc) ev[owner] = 1'b1;
            acc = busy && cyc == acc_cyc;
            check("req_ready", {62'b0, p1_req_ready, p0_req_ready}, {62'b0, er});
            check("rsp_valid", {62'b0, p1_rsp_valid, p0_rsp_valid}, {62'b0, ev});
            check("mem_strobe", {62'b0, mem_read, mem_write}, {62'b0, acc && !m_wr, acc && m_wr});
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_wdata", mem_wdata, m_wd);
            if (ev[0]) begin
                check("p0_rdata", p0_rsp_rdata, exp_rd);
                check("p0_err", 64'(p0_rsp_err), 64'(exp_err));
            end
            if (ev[1]) begin
                check("p1_rdata", p1_rsp_rdata, exp_rd);
                check("p1_err", 64'(p1_rsp_err), 64'(exp_err));
            end
            if (acc && m_wr) ref_mem[m_addr[5:3]] <= m_wd;
            if (acc && !m_wr) exp_rd = ref_mem[m_addr[5:3]];
            if (ev != 2'b00 && rr[owner]) busy = 0;
            else if (!busy && (v[0] || v[1])) begin
                busy = 1; owner = win; last = win;
                m_wr = w[win]; m_addr = a[win]; m_wd = d[win];
                exp_rd = '0;
                exp_err = a[win][2:0] != 3'b000;
                acc_cyc = exp_err ? 0 : cyc + 1;
                rsp_cyc = exp_err ? cyc + 1 : cyc + 2;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int p, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] da);
        bit done = 0;
        v[p] = 1; w[p] = wr; a[p] = ad; d[p] = da;
        for (int i = 0; i < 50 && !done; i++) begin
            cycles(1);
            done = hs[p];
        end
        v[p] = 0;
        check("req_accepted", 64'(done), 1);
    endtask

    logic [DW-1:0] old;
    logic [AW-1:0] r;
    int            exp_g;

    initial begin
        for (int i = 0; i < 8; i++) begin
            old = (i == 1) ? 64'h2 : {$urandom(), $urandom()};
            ref_mem[i] <= old;
            for (int b = 0; b < 8; b++) mem[8*i+b] <= old[8*b+:8];
        end
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; w[p] = 0; a[p] = '0; d[p] = '0; rr[p] = 1;
        end
        cycles(1);
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++) begin
                v[p] = 1'($urandom()); w[p] = 1'($urandom()); a[p] = AW'($urandom());
                d[p] = {$urandom(), $urandom()}; rr[p] = 1'($urandom());
            end
            cycles(1);
        end
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; rr[p] = 1;
        end
        rst_n = 1;
        issue(0, 0, 6'h08, '0);
        cycles(4);
        issue(1, 1, 6'h10, 64'hDEADBEEF_CAFEF00D);
        cycles(3);
        check("store_word", word(6'h10), 64'hDEADBEEF_CAFEF00D);
        issue(1, 0, 6'h10, '0);
        cycles(4);
        // simultaneous requests straight out of reset
        rst_n = 0;
        cycles(2);
        rst_n = 1;
        grants.delete();
        v[0] = 1; w[0] = 0; a[0] = 6'h20;
        v[1] = 1; w[1] = 0; a[1] = 6'h28;
        for (int i = 0; i < 40 && grants.size() < 4; i++) cycles(1);
        v[0] = 0; v[1] = 0;
        cycles(4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            check($sformatf("grant%0d", i), 64'(i < grants.size() ? grants[i] : 9), 64'(exp_g));
        end
        issue(0, 0, 6'h0B, '0);
        cycles(3);
        // backpressure: p0 holds its response while p1 waits
        rr[0] = 0;
        issue(0, 0, 6'h18, '0);
        v[1] = 1; w[1] = 0; a[1] = 6'h20;
        cycles(7);
        rr[0] = 1;
        for (int i = 0; i < 20 && !hs[1]; i++) cycles(1);
        v[1] = 0;
        check("bp_p1_served", 64'(hs[1]), 1);
        cycles(4);
        // reset pulse during the ACCESS cycle of a store
        old = word(6'h18);
        issue(0, 1, 6'h18, ~old);
        rst_n = 0;
        cycles(1);
        rst_n = 1;
        cycles(2);
        check("rst_store_word", word(6'h18), old);
        issue(0, 0, 6'h18, '0);
        cycles(4);
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) v[p] = 0;
                if (!v[p] && $urandom_range(0, 2) == 0) begin
                    r = AW'($urandom());
                    v[p] = 1; w[p] = 1'($urandom());
                    a[p] = ($urandom_range(0, 4) == 0) ? r : {r[5:3], 3'b000};
                    d[p] = {$urandom(), $urandom()};
                end
                rr[p] = $urandom_range(0, 3) != 0;
            end
            cycles(1);
        end
        for (int p = 0; p < 2; p++) rr[p] = 1;
        for (int i = 0; i < 20; i++) begin
            for (int p = 0; p < 2; p++) if (hs[p]) v[p] = 0;
            cycles(1);
        end
        v[0] = 0; v[1] = 0;
        cycles(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
